// File: rtl/syn_fifo.sv
// Single-clock byte FIFO with registered read data, full/empty flags and a live
// occupancy count. Reset clears pointers, count and buf_out but not the storage.
module syn_fifo #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [DATA_WIDTH-1:0]  buf_in,
    output logic [DATA_WIDTH-1:0]  buf_out,
    output logic                   buf_empty,
    output logic                   buf_full,
    output logic [COUNT_WIDTH-1:0] fifo_counter
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  mem_q [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0]  buf_out_q, buf_out_d;
    logic                   wr_acc, rd_acc;

    assign buf_empty    = (count_q == '0);
    assign buf_full     = (count_q == COUNT_WIDTH'(DEPTH));
    assign buf_out      = buf_out_q;
    assign fifo_counter = count_q;

    // A write into a full FIFO is allowed when a read frees the slot in the same edge.
    assign wr_acc = wr_en && (!buf_full || rd_en);
    assign rd_acc = rd_en && !buf_empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        buf_out_d = buf_out_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
            buf_out_d = mem_q[rd_ptr_q];
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            buf_out_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            buf_out_q <= buf_out_d;
        end
    end

    // Storage is not reset; a write coinciding with reset is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= buf_in;
        end
    end

endmodule

// File: tb/tb_syn_fifo.sv
// Directed self-checking bench for syn_fifo: reset, ordering, full/empty
// boundaries, simultaneous access and mid-stream reset.
module tb_syn_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  buf_in;
    logic [7:0]  buf_out;
    logic        buf_empty;
    logic        buf_full;
    logic [15:0] fifo_counter;

    int total = 0;
    int bad   = 0;

    syn_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .buf_in(buf_in),
        .buf_out(buf_out), .buf_empty(buf_empty), .buf_full(buf_full),
        .fifo_counter(fifo_counter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one edge with the given controls, then return to idle 1ns after it.
    task automatic cyc(input logic r, input logic w, input logic rd, input logic [7:0] d);
        rst = r; wr_en = w; rd_en = rd; buf_in = d;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; buf_in = 8'h00;

        // 1: reset held 2 edges with enables toggling
        cyc(1'b1, 1'b1, 1'b0, 8'h5A);
        cyc(1'b1, 1'b0, 1'b1, 8'hA5);
        chk("rst_out",   buf_out, 16'h00);
        chk("rst_cnt",   fifo_counter, 16'd0);
        chk("rst_empty", buf_empty, 16'd1);
        chk("rst_full",  buf_full, 16'd0);

        // 2: basic order
        cyc(1'b0, 1'b1, 1'b0, 8'h01);
        chk("nofall_out", buf_out, 16'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h02);
        cyc(1'b0, 1'b1, 1'b0, 8'h03);
        chk("b_cnt3",   fifo_counter, 16'd3);
        chk("b_empty0", buf_empty, 16'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("b_rd1", buf_out, 16'h01);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("b_rd2", buf_out, 16'h02);
        chk("b_cnt1", fifo_counter, 16'd1);

        // 3: continued order, then read while empty
        for (int i = 4; i <= 7; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
        chk("c_cnt5", fifo_counter, 16'd5);
        for (int i = 3; i <= 7; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("c_rd", buf_out, 16'(i));
        end
        chk("c_empty", buf_empty, 16'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("c_rdempty_out", buf_out, 16'h07);
        chk("c_rdempty_cnt", fifo_counter, 16'd0);

        // 4: fill, overflow write ignored, drain
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'(i));
            if (i == 62) chk("f_notfull63", buf_full, 16'd0);
        end
        chk("f_full",  buf_full, 16'd1);
        chk("f_cnt64", fifo_counter, 16'd64);
        cyc(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("f_ovf_cnt",  fifo_counter, 16'd64);
        chk("f_ovf_full", buf_full, 16'd1);
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("f_drain", buf_out, 16'(i));
        end
        chk("f_drain_empty", buf_empty, 16'd1);
        chk("f_drain_cnt",   fifo_counter, 16'd0);

        // 5a: simultaneous with count=3
        cyc(1'b0, 1'b1, 1'b0, 8'h10);
        cyc(1'b0, 1'b1, 1'b0, 8'h11);
        cyc(1'b0, 1'b1, 1'b0, 8'h12);
        begin
            logic [7:0] exp_q [4];
            exp_q = '{8'h10, 8'h11, 8'h12, 8'h20};
            for (int i = 0; i < 4; i++) begin
                cyc(1'b0, 1'b1, 1'b1, 8'(8'h20 + i));
                chk("s_out", buf_out, 16'(exp_q[i]));
                chk("s_cnt", fifo_counter, 16'd3);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("s_tail", buf_out, 16'(8'h20 + i));
        end
        chk("s_empty", buf_empty, 16'd1);

        // 5b: simultaneous while empty -> write only
        cyc(1'b0, 1'b1, 1'b1, 8'h55);
        chk("se_cnt", fifo_counter, 16'd1);
        chk("se_out", buf_out, 16'h23);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("se_rd", buf_out, 16'h55);

        // 5c: simultaneous while full -> both accepted
        for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        cyc(1'b0, 1'b1, 1'b1, 8'hEE);
        chk("sf_out",  buf_out, 16'h80);
        chk("sf_cnt",  fifo_counter, 16'd64);
        chk("sf_full", buf_full, 16'd1);
        for (int i = 1; i < 64; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("sf_drain", buf_out, 16'(8'h80 + i));
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("sf_last", buf_out, 16'hEE);
        chk("sf_empty", buf_empty, 16'd1);

        // 6: reset mid-stream (write asserted during reset is overridden)
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        chk("r_cnt5", fifo_counter, 16'd5);
        cyc(1'b1, 1'b1, 1'b1, 8'h77);
        chk("r_cnt",   fifo_counter, 16'd0);
        chk("r_empty", buf_empty, 16'd1);
        chk("r_out",   buf_out, 16'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h99);
        chk("r_wcnt", fifo_counter, 16'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("r_rd",  buf_out, 16'h99);
        chk("r_cnt0", fifo_counter, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/syn_fifo.md
Name: syn_fifo

Overview:
Single-clock synchronous FIFO buffering byte-wide data between a producer and a consumer in the same clock domain. Writes and reads are qualified by enables. Full/empty flags and a live occupancy counter are provided. Reads are registered: data appears on buf_out one clock after an accepted read.

Parameters:
DATA_WIDTH, 8, width of buf_in/buf_out
ADDR_WIDTH, 6, pointer width; depth = 2**ADDR_WIDTH = 64 entries
COUNT_WIDTH, 16, width of fifo_counter; must be >= ADDR_WIDTH+1

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  write request, sampled on rising clk
rd_en  input  1  read request, sampled on rising clk
buf_in  input  DATA_WIDTH  write data, captured when a write is accepted
buf_out  output  DATA_WIDTH  registered read data
buf_empty  output  1  high when occupancy == 0
buf_full  output  1  high when occupancy == depth
fifo_counter  output  COUNT_WIDTH  current occupancy, 0..depth

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled only on rising clk, and it overrides wr_en/rd_en in that cycle.
- Reset values:
  - buf_out = 0, fifo_counter = 0, buf_empty = 1, buf_full = 0.
  - Read and write pointers = 0.
  - Storage contents are not cleared.
- Flags are combinational decodes of fifo_counter: buf_empty = (count == 0); buf_full = (count == depth).
- Write accepted = wr_en && (!buf_full || rd_en).
  - On accept: mem[wr_ptr] <= buf_in; wr_ptr increments.
- Read accepted = rd_en && !buf_empty.
  - On accept: buf_out <= mem[rd_ptr]; rd_ptr increments.
  - Latency is 1 clock: data is valid after the accepting edge.
- buf_out holds its last value whenever no read is accepted, including reads attempted while empty.
- Pointers are ADDR_WIDTH bits and wrap naturally from depth-1 to 0.
- Counter updates:
  - write only: +1
  - read only: -1
  - both accepted: unchanged
  - neither: unchanged
- Boundary cases:
  - Write while full, no read: ignored; no pointer, count or memory change.
  - Read while empty: ignored; buf_out, pointers and count unchanged.
  - Simultaneous wr_en and rd_en while empty: the write is accepted, the read is ignored; count becomes 1.
  - Simultaneous wr_en and rd_en while full: both are accepted; the oldest entry is output, new data is stored in the freed slot, count stays at depth.
  - Simultaneous wr_en and rd_en otherwise: both are accepted; FIFO order is preserved.
- Reset mid-operation: all state returns to reset values on the next edge; any queued data is discarded.
- Data order is strict first-in first-out. No fall-through: empty-to-nonempty does not change buf_out.

Test Plan:
1. Reset: hold rst=1 for 2 clocks with wr_en/rd_en toggling -> buf_out=0x00, fifo_counter=0, buf_empty=1, buf_full=0.
2. Basic order:
   - Write 0x01, 0x02, 0x03 on 3 consecutive edges -> fifo_counter=3, buf_empty=0.
   - Then read 2 edges -> buf_out=0x01, then 0x02; fifo_counter=1.
3. Continued order and wrap of contents:
   - Write 0x04..0x07 -> fifo_counter=5.
   - Read 5 edges -> buf_out sequence 0x03, 0x04, 0x05, 0x06, 0x07; then buf_empty=1.
   - A further read leaves buf_out=0x07 and fifo_counter=0.
4. Full:
   - Write 64 values 0x00..0x3F -> buf_full=1, fifo_counter=64.
   - Extra write of 0xAA -> ignored, count stays 64.
   - Read all 64 -> outputs 0x00..0x3F in order; 0xAA never appears.
5. Simultaneous access:
   - With count=3, assert wr_en and rd_en together for 4 edges -> count stays 3, oldest data is output each edge.
   - From empty, wr_en+rd_en together -> count=1, buf_out unchanged.
   - When full, wr_en+rd_en together -> count=64, buf_full stays 1.
6. Reset mid-stream: after writing 5 entries, assert rst for one edge -> count=0, buf_empty=1, buf_out=0; the next write/read pair returns the newly written value.
